rs_unified: RTL and testbench

Parametrised reservation station: the next generation of the per-FU station. It adds configurable depth, multiple result-broadcast ports, valid/ready handshakes on allocate and issue, age-ordered issue, and selective mispredict flush. It sits between the ROB dispatch path and one functional unit (ALU or LS); the top level instantiates one copy per FU.

---
 rtl/rs_unified.sv | 234 +++++++++++++++++++++++
 tb/tb_rs_unified.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_unified.sv
// Reservation station for one FU: captures dispatched ops, wakes operands/flags from broadcast ports and issues with a valid/ready handshake.
// Issue is combinational from held state (1-cycle alloc-to-issue); alloc stalls when full or flushing. `RS_AGE_ORDER_EN selects oldest-first issue.
module rs_unified #(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_IDX_W = 4,
    parameter int VAL_W     = 64,
    parameter int OP_W      = 6,
    parameter int NUM_BCAST = 2
) (
    input  logic                           in_clk,
    input  logic                           in_rst_n,
    input  logic                           in_alloc_valid,
    output logic                           out_alloc_ready,
    input  logic [OP_W-1:0]                in_alloc_op,
    input  logic [ROB_IDX_W-1:0]           in_alloc_dst_rob,
    input  logic                           in_alloc_a_valid,
    input  logic                           in_alloc_b_valid,
    input  logic [VAL_W-1:0]               in_alloc_a_value,
    input  logic [VAL_W-1:0]               in_alloc_b_value,
    input  logic [ROB_IDX_W-1:0]           in_alloc_a_rob,
    input  logic [ROB_IDX_W-1:0]           in_alloc_b_rob,
    input  logic                           in_alloc_uses_nzcv,
    input  logic                           in_alloc_nzcv_valid,
    input  logic                           in_alloc_set_nzcv,
    input  logic [3:0]                     in_alloc_nzcv,
    input  logic [ROB_IDX_W-1:0]           in_alloc_nzcv_rob,
    input  logic [NUM_BCAST-1:0]           in_bcast_valid,
    input  logic [NUM_BCAST*ROB_IDX_W-1:0] in_bcast_rob,
    input  logic [NUM_BCAST*VAL_W-1:0]     in_bcast_value,
    input  logic [NUM_BCAST-1:0]           in_bcast_set_nzcv,
    input  logic [NUM_BCAST*4-1:0]         in_bcast_nzcv,
    input  logic [ROB_IDX_W-1:0]           in_rob_head,
    input  logic                           in_flush_valid,
    input  logic [ROB_IDX_W-1:0]           in_flush_rob,
    output logic                           out_issue_valid,
    input  logic                           in_issue_ready,
    output logic [OP_W-1:0]                out_issue_op,
    output logic [VAL_W-1:0]               out_issue_val_a,
    output logic [VAL_W-1:0]               out_issue_val_b,
    output logic [ROB_IDX_W-1:0]           out_issue_dst_rob,
    output logic [3:0]                     out_issue_nzcv,
    output logic                           out_issue_set_nzcv,
    output logic [$clog2(RS_DEPTH+1)-1:0]  out_count,
    output logic                           out_full,
    output logic                           out_empty
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic                 vld;
        logic [OP_W-1:0]      op;
        logic [ROB_IDX_W-1:0] dst;
        logic                 a_vld;
        logic [VAL_W-1:0]     a_val;
        logic [ROB_IDX_W-1:0] a_rob;
        logic                 b_vld;
        logic [VAL_W-1:0]     b_val;
        logic [ROB_IDX_W-1:0] b_rob;
        logic                 uses_nzcv;
        logic                 nzcv_vld;
        logic [3:0]           nzcv;
        logic [ROB_IDX_W-1:0] nzcv_rob;
        logic                 set_nzcv;
    } entry_t;

    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] rdy;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic [CNT_W-1:0]    cnt;
    logic                issue_fire;
    logic                alloc_fire;
    entry_t              new_ent;

    // Head-relative age; modular subtraction makes tag wrap-around transparent.
    function automatic logic [ROB_IDX_W-1:0] age_of(input logic [ROB_IDX_W-1:0] tag,
                                                    input logic [ROB_IDX_W-1:0] head);
        return tag - head;
    endfunction

    // Lowest matching port wins because a captured field is already valid for later ports.
    function automatic entry_t wake(input entry_t                           e,
                                    input logic [NUM_BCAST-1:0]           bv,
                                    input logic [NUM_BCAST*ROB_IDX_W-1:0] brob,
                                    input logic [NUM_BCAST*VAL_W-1:0]     bval,
                                    input logic [NUM_BCAST-1:0]           bset,
                                    input logic [NUM_BCAST*4-1:0]         bnzcv);
        entry_t r;
        r = e;
        for (int p = 0; p < NUM_BCAST; p++) begin
            if (bv[p]) begin
                if (!r.a_vld && brob[p*ROB_IDX_W +: ROB_IDX_W] == r.a_rob) begin
                    r.a_vld = 1'b1;
                    r.a_val = bval[p*VAL_W +: VAL_W];
                end
                if (!r.b_vld && brob[p*ROB_IDX_W +: ROB_IDX_W] == r.b_rob) begin
                    r.b_vld = 1'b1;
                    r.b_val = bval[p*VAL_W +: VAL_W];
                end
                if (!r.nzcv_vld && bset[p] && brob[p*ROB_IDX_W +: ROB_IDX_W] == r.nzcv_rob) begin
                    r.nzcv_vld = 1'b1;
                    r.nzcv     = bnzcv[p*4 +: 4];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        rdy = '0;
        cnt = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rdy[i] = ent_q[i].vld & ent_q[i].a_vld & ent_q[i].b_vld &
                     (~ent_q[i].uses_nzcv | ent_q[i].nzcv_vld);
            cnt = cnt + CNT_W'(ent_q[i].vld);
            if (!ent_q[i].vld && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    logic [ROB_IDX_W-1:0] best_age;
`endif

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
        best_age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (rdy[i] && (!sel_found || age_of(ent_q[i].dst, in_rob_head) < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age_of(ent_q[i].dst, in_rob_head);
            end
        end
`else
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (rdy[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`endif
    end

    assign out_count       = cnt;
    assign out_full        = (cnt == CNT_W'(RS_DEPTH));
    assign out_empty       = (cnt == '0);
    assign out_alloc_ready = ~out_full & ~in_flush_valid;
    assign alloc_fire      = in_alloc_valid & out_alloc_ready & free_found;
    assign out_issue_valid = sel_found & ~in_flush_valid;
    assign issue_fire      = out_issue_valid & in_issue_ready;

    always_comb begin
        out_issue_op       = '0;
        out_issue_val_a    = '0;
        out_issue_val_b    = '0;
        out_issue_dst_rob  = '0;
        out_issue_nzcv     = '0;
        out_issue_set_nzcv = 1'b0;
        if (out_issue_valid) begin
            out_issue_op       = ent_q[sel_idx].op;
            out_issue_val_a    = ent_q[sel_idx].a_val;
            out_issue_val_b    = ent_q[sel_idx].b_val;
            out_issue_dst_rob  = ent_q[sel_idx].dst;
            out_issue_nzcv     = ent_q[sel_idx].nzcv;
            out_issue_set_nzcv = ent_q[sel_idx].set_nzcv;
        end
    end

    always_comb begin
        new_ent           = '0;
        new_ent.vld       = 1'b1;
        new_ent.op        = in_alloc_op;
        new_ent.dst       = in_alloc_dst_rob;
        new_ent.a_vld     = in_alloc_a_valid;
        new_ent.a_val     = in_alloc_a_value;
        new_ent.a_rob     = in_alloc_a_rob;
        new_ent.b_vld     = in_alloc_b_valid;
        new_ent.b_val     = in_alloc_b_value;
        new_ent.b_rob     = in_alloc_b_rob;
        new_ent.uses_nzcv = in_alloc_uses_nzcv;
        new_ent.nzcv_vld  = in_alloc_nzcv_valid;
        new_ent.nzcv      = in_alloc_nzcv;
        new_ent.nzcv_rob  = in_alloc_nzcv_rob;
        new_ent.set_nzcv  = in_alloc_set_nzcv;
    end

    // Slot choice uses pre-issue occupancy, so an issuing entry is never reused in the same cycle.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i].vld ? wake(ent_q[i], in_bcast_valid, in_bcast_rob, in_bcast_value,
                                           in_bcast_set_nzcv, in_bcast_nzcv)
                                    : ent_q[i];
        end
        if (issue_fire) begin
            ent_d[sel_idx].vld = 1'b0;
        end
        if (in_flush_valid) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (age_of(ent_q[i].dst, in_rob_head) > age_of(in_flush_rob, in_rob_head)) begin
                    ent_d[i].vld = 1'b0;
                end
            end
        end
        if (alloc_fire) begin
            ent_d[free_idx] = wake(new_ent, in_bcast_valid, in_bcast_rob, in_bcast_value,
                                   in_bcast_set_nzcv, in_bcast_nzcv);
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_unified.sv
// Scoreboard bench for rs_unified: expected issues queued at dispatch, popped and compared when the FU handshake shows them.
module tb_rs_unified;
    localparam int RS_DEPTH  = 8;
    localparam int ROB_IDX_W = 4;
    localparam int VAL_W     = 64;
    localparam int OP_W      = 6;
    localparam int NUM_BCAST = 2;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [VAL_W-1:0]     a;
        logic [VAL_W-1:0]     b;
        logic [ROB_IDX_W-1:0] dst;
        logic [3:0]           nzcv;
        logic                 setf;
    } exp_t;

    logic                           in_clk = 1'b0;
    logic                           in_rst_n;
    logic                           in_alloc_valid;
    logic                           out_alloc_ready;
    logic [OP_W-1:0]                in_alloc_op;
    logic [ROB_IDX_W-1:0]           in_alloc_dst_rob;
    logic                           in_alloc_a_valid, in_alloc_b_valid;
    logic [VAL_W-1:0]               in_alloc_a_value, in_alloc_b_value;
    logic [ROB_IDX_W-1:0]           in_alloc_a_rob, in_alloc_b_rob;
    logic                           in_alloc_uses_nzcv, in_alloc_nzcv_valid, in_alloc_set_nzcv;
    logic [3:0]                     in_alloc_nzcv;
    logic [ROB_IDX_W-1:0]           in_alloc_nzcv_rob;
    logic [NUM_BCAST-1:0]           in_bcast_valid;
    logic [NUM_BCAST*ROB_IDX_W-1:0] in_bcast_rob;
    logic [NUM_BCAST*VAL_W-1:0]     in_bcast_value;
    logic [NUM_BCAST-1:0]           in_bcast_set_nzcv;
    logic [NUM_BCAST*4-1:0]         in_bcast_nzcv;
    logic [ROB_IDX_W-1:0]           in_rob_head;
    logic                           in_flush_valid;
    logic [ROB_IDX_W-1:0]           in_flush_rob;
    logic                           out_issue_valid;
    logic                           in_issue_ready;
    logic [OP_W-1:0]                out_issue_op;
    logic [VAL_W-1:0]               out_issue_val_a, out_issue_val_b;
    logic [ROB_IDX_W-1:0]           out_issue_dst_rob;
    logic [3:0]                     out_issue_nzcv;
    logic                           out_issue_set_nzcv;
    logic [$clog2(RS_DEPTH+1)-1:0]  out_count;
    logic                           out_full, out_empty;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    rs_unified #(
        .RS_DEPTH(RS_DEPTH), .ROB_IDX_W(ROB_IDX_W), .VAL_W(VAL_W), .OP_W(OP_W), .NUM_BCAST(NUM_BCAST)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_alloc_valid(in_alloc_valid), .out_alloc_ready(out_alloc_ready),
        .in_alloc_op(in_alloc_op), .in_alloc_dst_rob(in_alloc_dst_rob),
        .in_alloc_a_valid(in_alloc_a_valid), .in_alloc_b_valid(in_alloc_b_valid),
        .in_alloc_a_value(in_alloc_a_value), .in_alloc_b_value(in_alloc_b_value),
        .in_alloc_a_rob(in_alloc_a_rob), .in_alloc_b_rob(in_alloc_b_rob),
        .in_alloc_uses_nzcv(in_alloc_uses_nzcv), .in_alloc_nzcv_valid(in_alloc_nzcv_valid),
        .in_alloc_set_nzcv(in_alloc_set_nzcv), .in_alloc_nzcv(in_alloc_nzcv),
        .in_alloc_nzcv_rob(in_alloc_nzcv_rob),
        .in_bcast_valid(in_bcast_valid), .in_bcast_rob(in_bcast_rob), .in_bcast_value(in_bcast_value),
        .in_bcast_set_nzcv(in_bcast_set_nzcv), .in_bcast_nzcv(in_bcast_nzcv),
        .in_rob_head(in_rob_head), .in_flush_valid(in_flush_valid), .in_flush_rob(in_flush_rob),
        .out_issue_valid(out_issue_valid), .in_issue_ready(in_issue_ready),
        .out_issue_op(out_issue_op), .out_issue_val_a(out_issue_val_a), .out_issue_val_b(out_issue_val_b),
        .out_issue_dst_rob(out_issue_dst_rob), .out_issue_nzcv(out_issue_nzcv),
        .out_issue_set_nzcv(out_issue_set_nzcv),
        .out_count(out_count), .out_full(out_full), .out_empty(out_empty)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    function automatic exp_t mk_exp(input logic [OP_W-1:0] op, input logic [VAL_W-1:0] a,
                                    input logic [VAL_W-1:0] b, input logic [ROB_IDX_W-1:0] dst,
                                    input logic [3:0] nzcv, input logic setf);
        exp_t r;
        r.op = op; r.a = a; r.b = b; r.dst = dst; r.nzcv = nzcv; r.setf = setf;
        return r;
    endfunction

    function automatic exp_t cur_issue();
        return mk_exp(out_issue_op, out_issue_val_a, out_issue_val_b, out_issue_dst_rob,
                      out_issue_nzcv, out_issue_set_nzcv);
    endfunction

    task automatic drive_alloc(input logic [OP_W-1:0] op, input logic [ROB_IDX_W-1:0] dst,
                               input logic av, input logic [VAL_W-1:0] a, input logic [ROB_IDX_W-1:0] arob,
                               input logic bv, input logic [VAL_W-1:0] b, input logic [ROB_IDX_W-1:0] brob);
        in_alloc_valid = 1'b1; in_alloc_op = op; in_alloc_dst_rob = dst;
        in_alloc_a_valid = av; in_alloc_a_value = a; in_alloc_a_rob = arob;
        in_alloc_b_valid = bv; in_alloc_b_value = b; in_alloc_b_rob = brob;
    endtask

    task automatic set_bcast(input int p, input logic [ROB_IDX_W-1:0] tag, input logic [VAL_W-1:0] val,
                             input logic setf, input logic [3:0] nzcv);
        in_bcast_valid[p] = 1'b1;
        in_bcast_rob[p*ROB_IDX_W +: ROB_IDX_W] = tag;
        in_bcast_value[p*VAL_W +: VAL_W] = val;
        in_bcast_set_nzcv[p] = setf;
        in_bcast_nzcv[p*4 +: 4] = nzcv;
    endtask

    task automatic clr_inputs();
        in_alloc_valid = 1'b0;
        in_alloc_uses_nzcv = 1'b0; in_alloc_nzcv_valid = 1'b0; in_alloc_set_nzcv = 1'b0;
        in_alloc_nzcv = '0; in_alloc_nzcv_rob = '0;
        in_bcast_valid = '0; in_bcast_rob = '0; in_bcast_value = '0;
        in_bcast_set_nzcv = '0; in_bcast_nzcv = '0;
        in_flush_valid = 1'b0; in_flush_rob = '0;
    endtask

    // Bounded wait for an offered issue; callers treat a timeout as a failed comparison.
    task automatic wait_issue(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_issue_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick(); #2;
        end
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        tick(); tick(); #2;
        checks++;
        if (out_issue_valid !== 1'b0 || out_alloc_ready !== 1'b1 || out_count !== '0 ||
            out_empty !== 1'b1 || out_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: iv=%b ar=%b cnt=%0d e=%b f=%b want 0 1 0 1 0",
                     out_issue_valid, out_alloc_ready, out_count, out_empty, out_full);
        end
        checks++;
        if (cur_issue() !== mk_exp('0, '0, '0, '0, '0, 1'b0)) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", cur_issue());
        end
        in_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        exp_t e; bit got;
        in_issue_ready = 1'b1;
        drive_alloc(6'd3, 4'd2, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 4'd0);
        exp_q.push_back(mk_exp(6'd3, 64'd5, 64'd7, 4'd2, 4'd0, 1'b0));
        tick(); clr_inputs(); #2;
        checks++;
        if (out_issue_valid !== 1'b1 || out_count !== 4'd1) begin
            errors++;
            $display("FAIL basic_latency: iv=%b cnt=%0d want 1 1", out_issue_valid, out_count);
        end
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL basic_issue: got %h want %h", cur_issue(), e);
        end
        tick(); #2;
        checks++;
        if (out_count !== '0 || out_empty !== 1'b1 || out_issue_valid !== 1'b0 || out_issue_val_a !== '0) begin
            errors++;
            $display("FAIL basic_free: cnt=%0d e=%b iv=%b a=%h want 0 1 0 0",
                     out_count, out_empty, out_issue_valid, out_issue_val_a);
        end
    endtask

    task automatic test_wakeup();
        exp_t e; bit got;
        in_issue_ready = 1'b1;
        drive_alloc(6'd1, 4'd4, 1'b0, 64'd0, 4'd1, 1'b1, 64'd3, 4'd0);
        exp_q.push_back(mk_exp(6'd1, 64'h2A, 64'd3, 4'd4, 4'd0, 1'b0));
        tick(); clr_inputs(); #2;
        checks++;
        if (out_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_wait: iv=%b want 0", out_issue_valid);
        end
        set_bcast(1, 4'd1, 64'h2A, 1'b0, 4'd0);
        tick(); clr_inputs(); #2;
        checks++;
        if (out_issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL wake_timing: iv=%b want 1", out_issue_valid);
        end
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL wake_issue: got %h want %h", cur_issue(), e);
        end
        tick();
    endtask

    task automatic test_dup_tag();
        exp_t e; bit got;
        in_issue_ready = 1'b1;
        drive_alloc(6'd2, 4'd11, 1'b0, 64'd0, 4'd7, 1'b1, 64'd0, 4'd0);
        exp_q.push_back(mk_exp(6'd2, 64'h11, 64'd0, 4'd11, 4'd0, 1'b0));
        tick(); clr_inputs();
        set_bcast(0, 4'd7, 64'h11, 1'b0, 4'd0);
        set_bcast(1, 4'd7, 64'h22, 1'b0, 4'd0);
        tick(); clr_inputs(); #2;
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL dup_tag_port0: got %h want %h", cur_issue(), e);
        end
        tick();
    endtask

    task automatic test_bypass();
        exp_t e; bit got;
        in_issue_ready = 1'b1;
        drive_alloc(6'd4, 4'd8, 1'b1, 64'd1, 4'd0, 1'b0, 64'd0, 4'd6);
        set_bcast(0, 4'd6, 64'd9, 1'b0, 4'd0);
        exp_q.push_back(mk_exp(6'd4, 64'd1, 64'd9, 4'd8, 4'd0, 1'b0));
        tick(); clr_inputs(); #2;
        checks++;
        if (out_issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready: iv=%b want 1", out_issue_valid);
        end
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL bypass_issue: got %h want %h", cur_issue(), e);
        end
        tick();
    endtask

    task automatic test_nzcv();
        exp_t e; bit got;
        in_issue_ready = 1'b1;
        drive_alloc(6'd9, 4'd10, 1'b1, 64'd1, 4'd0, 1'b1, 64'd2, 4'd0);
        in_alloc_uses_nzcv = 1'b1; in_alloc_nzcv_valid = 1'b0;
        in_alloc_nzcv_rob = 4'd9; in_alloc_set_nzcv = 1'b1;
        exp_q.push_back(mk_exp(6'd9, 64'd1, 64'd2, 4'd10, 4'hA, 1'b1));
        tick(); clr_inputs();
        set_bcast(0, 4'd9, 64'd0, 1'b0, 4'h5);
        tick(); clr_inputs(); #2;
        checks++;
        if (out_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL nzcv_no_set: iv=%b want 0", out_issue_valid);
        end
        set_bcast(1, 4'd9, 64'd0, 1'b1, 4'hA);
        tick(); clr_inputs(); #2;
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL nzcv_issue: got %h want %h", cur_issue(), e);
        end
        tick();
    endtask

    task automatic test_age_order();
        exp_t e; bit got;
        in_issue_ready = 1'b0;
        in_rob_head = 4'd14;
        drive_alloc(6'd5, 4'd1, 1'b1, 64'd100, 4'd0, 1'b1, 64'd101, 4'd0);
        tick();
        drive_alloc(6'd6, 4'd15, 1'b1, 64'd200, 4'd0, 1'b1, 64'd201, 4'd0);
        tick(); clr_inputs();
`ifdef RS_AGE_ORDER_EN
        exp_q.push_back(mk_exp(6'd6, 64'd200, 64'd201, 4'd15, 4'd0, 1'b0));
        exp_q.push_back(mk_exp(6'd5, 64'd100, 64'd101, 4'd1, 4'd0, 1'b0));
`else
        exp_q.push_back(mk_exp(6'd5, 64'd100, 64'd101, 4'd1, 4'd0, 1'b0));
        exp_q.push_back(mk_exp(6'd6, 64'd200, 64'd201, 4'd15, 4'd0, 1'b0));
`endif
        in_issue_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            wait_issue(got); e = exp_q.pop_front();
            checks++;
            if (!got || cur_issue() !== e) begin
                errors++;
                $display("FAIL age_order_%0d: got %h want %h", k, cur_issue(), e);
            end
            tick();
        end
        #2;
        checks++;
        if (out_count !== '0) begin
            errors++;
            $display("FAIL age_drain: cnt=%0d want 0", out_count);
        end
        in_rob_head = 4'd0;
    endtask

    task automatic test_flush();
        exp_t e; bit got;
        in_issue_ready = 1'b0;
        in_rob_head = 4'd0;
        drive_alloc(6'd1, 4'd1, 1'b1, 64'd11, 4'd0, 1'b1, 64'd12, 4'd0); tick();
        drive_alloc(6'd3, 4'd3, 1'b1, 64'd31, 4'd0, 1'b1, 64'd32, 4'd0); tick();
        drive_alloc(6'd5, 4'd5, 1'b1, 64'd51, 4'd0, 1'b1, 64'd52, 4'd0); tick();
        drive_alloc(6'd7, 4'd7, 1'b1, 64'd71, 4'd0, 1'b1, 64'd72, 4'd0);
        in_flush_valid = 1'b1; in_flush_rob = 4'd3; #2;
        checks++;
        if (out_issue_valid !== 1'b0 || out_alloc_ready !== 1'b0 || out_count !== 4'd3) begin
            errors++;
            $display("FAIL flush_cycle: iv=%b ar=%b cnt=%0d want 0 0 3",
                     out_issue_valid, out_alloc_ready, out_count);
        end
        tick(); clr_inputs(); #2;
        checks++;
        if (out_count !== 4'd2 || out_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: cnt=%0d ar=%b want 2 1", out_count, out_alloc_ready);
        end
        exp_q.push_back(mk_exp(6'd1, 64'd11, 64'd12, 4'd1, 4'd0, 1'b0));
        exp_q.push_back(mk_exp(6'd3, 64'd31, 64'd32, 4'd3, 4'd0, 1'b0));
        in_issue_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            wait_issue(got); e = exp_q.pop_front();
            checks++;
            if (!got || cur_issue() !== e) begin
                errors++;
                $display("FAIL flush_survivor_%0d: got %h want %h", k, cur_issue(), e);
            end
            tick();
        end
        #2;
        checks++;
        if (out_count !== '0 || out_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_removed: cnt=%0d iv=%b want 0 0", out_count, out_issue_valid);
        end
    endtask

    task automatic test_full_and_reset();
        exp_t e; bit got;
        in_issue_ready = 1'b0;
        in_rob_head = 4'd0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            drive_alloc(6'(i), 4'(i), 1'b1, 64'(i * 10), 4'd0, 1'b1, 64'(i), 4'd0);
            tick();
        end
        drive_alloc(6'd8, 4'd8, 1'b1, 64'd80, 4'd0, 1'b1, 64'd8, 4'd0);
        #2;
        checks++;
        if (out_full !== 1'b1 || out_alloc_ready !== 1'b0 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL full_flags: f=%b ar=%b cnt=%0d want 1 0 8", out_full, out_alloc_ready, out_count);
        end
        tick(); #2;
        checks++;
        if (out_count !== 4'd8) begin
            errors++;
            $display("FAIL full_hold: cnt=%0d want 8", out_count);
        end
        exp_q.push_back(mk_exp(6'd0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b0));
        in_issue_ready = 1'b1; #1;
        wait_issue(got); e = exp_q.pop_front();
        checks++;
        if (!got || cur_issue() !== e) begin
            errors++;
            $display("FAIL full_issue: got %h want %h", cur_issue(), e);
        end
        tick(); in_issue_ready = 1'b0; #2;
        checks++;
        if (out_count !== 4'd7 || out_alloc_ready !== 1'b1 || out_full !== 1'b0) begin
            errors++;
            $display("FAIL full_release: cnt=%0d ar=%b f=%b want 7 1 0", out_count, out_alloc_ready, out_full);
        end
        in_rst_n = 1'b0; in_issue_ready = 1'b1;
        tick(); #2;
        checks++;
        if (out_count !== '0 || out_empty !== 1'b1 || out_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d e=%b iv=%b want 0 1 0", out_count, out_empty, out_issue_valid);
        end
        in_rst_n = 1'b1; clr_inputs(); in_issue_ready = 1'b0;
        tick();
    endtask

    initial begin
        in_rst_n = 1'b0;
        in_issue_ready = 1'b0;
        in_rob_head = '0;
        in_alloc_op = '0; in_alloc_dst_rob = '0;
        in_alloc_a_valid = 1'b0; in_alloc_b_valid = 1'b0;
        in_alloc_a_value = '0; in_alloc_b_value = '0;
        in_alloc_a_rob = '0; in_alloc_b_rob = '0;
        clr_inputs();
        test_reset();
        test_basic();
        test_wakeup();
        test_dup_tag();
        test_bypass();
        test_nzcv();
        test_age_order();
        test_flush();
        test_full_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
